// File: rtl/onehot_event_counter_if.sv
// onehot_event_counter_if: event, readback and clear signals of onehot_event_counter
interface onehot_event_counter_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
);
  localparam int N = 1 << SEL_W;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [SEL_W-1:0] io_in_sel;
  logic [N-1:0]     io_out;
  logic [SEL_W-1:0] io_rd_sel;
  logic [CNT_W-1:0] io_rd_cnt;
  logic             io_clear;
  logic             io_busy;
  logic             io_ovf;
  modport master (
    output io_in_valid, io_in_sel, io_rd_sel, io_clear,
    input  io_in_ready, io_out, io_rd_cnt, io_busy, io_ovf
  );
  modport slave (
    input  io_in_valid, io_in_sel, io_rd_sel, io_clear,
    output io_in_ready, io_out, io_rd_cnt, io_busy, io_ovf
  );
endinterface

// File: rtl/onehot_event_counter.sv
// onehot_event_counter: one-hot decode of accepted selects with per-channel event counters;
// define ONEHOT_CNT_SATURATE_EN to make counters saturate instead of wrap.
module onehot_event_counter #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input logic                   clock,
  input logic                   reset,
  onehot_event_counter_if.slave bus
);
  localparam int N = 1 << SEL_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t           state, state_next;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] cnt [N];
  logic [CNT_W-1:0] cur, inc;
  logic             accept, last;
  assign cur             = cnt[bus.io_in_sel];
  assign bus.io_in_ready = (state == IDLE) && !bus.io_clear;
  assign bus.io_busy     = (state == CLEAR);
  assign accept          = bus.io_in_valid && bus.io_in_ready;
  assign last            = (idx == SEL_W'(N - 1));
`ifdef ONEHOT_CNT_SATURATE_EN
  assign inc = &cur ? cur : cur + 1'b1;
`else
  assign inc = cur + 1'b1;
`endif
  // next state: clear request starts the sweep, last index ends it
  always_comb begin
    state_next = state;
    state_next = (state == IDLE) ? (bus.io_clear ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  end
  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end
  // counters, decode, readback, sweep index and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx           <= '0;
      bus.io_out    <= '0;
      bus.io_rd_cnt <= '0;
      bus.io_ovf    <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      bus.io_rd_cnt <= cnt[bus.io_rd_sel];
      if (accept) begin
        bus.io_out          <= N'(1) << bus.io_in_sel;
        cnt[bus.io_in_sel]  <= inc;
        if (&cur) bus.io_ovf <= 1'b1;
      end
      if (state == IDLE) idx <= '0;
      else begin
        cnt[idx] <= '0;
        idx      <= idx + 1'b1;
        if (last) begin
          bus.io_out <= '0;
          bus.io_ovf <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_onehot_event_counter.sv
// tb_onehot_event_counter: directed checks of decode, counting, overflow, clear sweep and reset
module tb_onehot_event_counter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  always #5 clock = ~clock;
  onehot_event_counter_if #(.SEL_W(3), .CNT_W(8)) ifa ();
  onehot_event_counter_if #(.SEL_W(3), .CNT_W(2)) ifb ();
  onehot_event_counter_if #(.SEL_W(1), .CNT_W(4)) ifc ();
  onehot_event_counter #(.SEL_W(3), .CNT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  onehot_event_counter #(.SEL_W(3), .CNT_W(2)) dut_b (.clock(clock), .reset(reset), .bus(ifb));
  onehot_event_counter #(.SEL_W(1), .CNT_W(4)) dut_c (.clock(clock), .reset(reset), .bus(ifc));
`ifdef ONEHOT_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic events_a(input logic [2:0] sel, input int n);
    ifa.io_in_valid = 1'b1;
    ifa.io_in_sel   = sel;
    repeat (n) step();
    ifa.io_in_valid = 1'b0;
  endtask
  task automatic read_a(input logic [2:0] sel, input logic [7:0] exp, input string tag);
    ifa.io_rd_sel = sel;
    step();
    check(tag, ifa.io_rd_cnt, exp);
  endtask
  task automatic sweep_len(input bit retrigger, output int n, output int ready_hi);
    n = 0;
    ready_hi = 0;
    for (int i = 0; i < 20 && ifa.io_busy; i++) begin
      if (ifa.io_in_ready) ready_hi++;
      if (retrigger && i == 3) ifa.io_clear = 1'b1;
      step();
      ifa.io_clear = 1'b0;
      n++;
    end
  endtask
  int n, rh;
  initial begin
    {ifa.io_in_valid, ifa.io_in_sel, ifa.io_rd_sel, ifa.io_clear} = '0;
    {ifb.io_in_valid, ifb.io_in_sel, ifb.io_rd_sel, ifb.io_clear} = '0;
    {ifc.io_in_valid, ifc.io_in_sel, ifc.io_rd_sel, ifc.io_clear} = '0;
    ifa.io_in_valid = 1'b1;
    ifa.io_in_sel   = 3'd5;
    ifa.io_rd_sel   = 3'd5;
    repeat (3) step();
    check("rst_out", ifa.io_out, 8'h00);
    check("rst_cnt5", ifa.io_rd_cnt, 8'd0);
    check("rst_ovf", ifa.io_ovf, 1'b0);
    check("rst_busy", ifa.io_busy, 1'b0);
    ifa.io_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_ready", ifa.io_in_ready, 1'b1);
    read_a(3'd5, 8'd0, "rst_ch5");
    ifa.io_in_valid = 1'b1;
    ifa.io_in_sel = 3'd0; step(); check("dec_0", ifa.io_out, 8'h01);
    ifa.io_in_sel = 3'd3; step(); check("dec_3a", ifa.io_out, 8'h08);
    step(); check("dec_3b", ifa.io_out, 8'h08);
    ifa.io_in_sel = 3'd7; step(); check("dec_7", ifa.io_out, 8'h80);
    ifa.io_in_valid = 1'b0;
    step(); check("dec_hold", ifa.io_out, 8'h80);
    read_a(3'd3, 8'd2, "cnt_ch3");
    read_a(3'd7, 8'd1, "cnt_ch7");
    read_a(3'd1, 8'd0, "cnt_ch1");
    read_a(3'd0, 8'd1, "cnt_ch0");
    events_a(3'd4, 255);
    check("ovf_255", ifa.io_ovf, 1'b0);
    events_a(3'd4, 1);
    check("ovf_256", ifa.io_ovf, 1'b1);
    check("dec_4", ifa.io_out, 8'h10);
    read_a(3'd4, SAT ? 8'd255 : 8'd0, "cnt_ch4");
    ifa.io_clear    = 1'b1;
    ifa.io_in_valid = 1'b1;
    ifa.io_in_sel   = 3'd1;
    #1;
    check("clr_ready", ifa.io_in_ready, 1'b0);
    step();
    ifa.io_clear    = 1'b0;
    ifa.io_in_valid = 1'b0;
    check("clr_busy", ifa.io_busy, 1'b1);
    check("clr_noacc", ifa.io_out, 8'h10);
    sweep_len(1'b1, n, rh);
    check("clr_len", n, 8);
    check("clr_ready_lo", rh, 0);
    check("clr_out", ifa.io_out, 8'h00);
    check("clr_ovf", ifa.io_ovf, 1'b0);
    check("clr_ready_hi", ifa.io_in_ready, 1'b1);
    read_a(3'd1, 8'd0, "clr_ch1");
    read_a(3'd3, 8'd0, "clr_ch3");
    read_a(3'd4, 8'd0, "clr_ch4");
    ifb.io_in_valid = 1'b1;
    ifb.io_in_sel   = 3'd2;
    repeat (3) step();
    check("b_ovf3", ifb.io_ovf, 1'b0);
    step();
    ifb.io_in_valid = 1'b0;
    check("b_ovf4", ifb.io_ovf, 1'b1);
    ifb.io_rd_sel = 3'd2;
    step();
    check("b_cnt2", ifb.io_rd_cnt, SAT ? 2'd3 : 2'd0);
    ifc.io_in_valid = 1'b1;
    ifc.io_in_sel   = 1'b1;
    repeat (16) step();
    ifc.io_in_valid = 1'b0;
    check("c_out", ifc.io_out, 2'b10);
    check("c_ovf", ifc.io_ovf, 1'b1);
    ifc.io_rd_sel = 1'b1; step(); check("c_cnt1", ifc.io_rd_cnt, SAT ? 4'd15 : 4'd0);
    ifc.io_rd_sel = 1'b0; step(); check("c_cnt0", ifc.io_rd_cnt, 4'd0);
    events_a(3'd6, 257);
    check("m_ovf", ifa.io_ovf, 1'b1);
    read_a(3'd6, SAT ? 8'd255 : 8'd1, "m_ch6");
    ifa.io_clear = 1'b1;
    step();
    ifa.io_clear = 1'b0;
    repeat (3) step();
    check("m_busy_pre", ifa.io_busy, 1'b1);
    reset = 1'b0;
    #1;
    check("m_busy", ifa.io_busy, 1'b0);
    check("m_ovf_rst", ifa.io_ovf, 1'b0);
    check("m_out", ifa.io_out, 8'h00);
    check("m_rdcnt", ifa.io_rd_cnt, 8'd0);
    check("m_b_ovf", ifb.io_ovf, 1'b0);
    step();
    reset = 1'b1;
    #1;
    check("m_ready", ifa.io_in_ready, 1'b1);
    read_a(3'd6, 8'd0, "m_ch6_rst");
    ifa.io_clear = 1'b1;
    step();
    ifa.io_clear = 1'b0;
    sweep_len(1'b0, n, rh);
    check("m_len", n, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onehot_event_counter.md
# onehot_event_counter

Parametrised successor to the fixed 3-bit decode/count black box. It accepts channel-select events over a valid/ready handshake and drives a registered one-hot decode of the last accepted select. It keeps a per-channel event counter for every one of the 2^SEL_W channels and exposes a registered readback port and a sticky overflow flag. The block sits behind the Chisel top-level wrapper as a Verilog resource, clocked from the top-level clock.

## Interface
Parameters:
- SEL_W, 3, select width; channel count N = 2^SEL_W (legal range 1..6).
- CNT_W, 8, per-channel counter width (legal range 2..32).

Ports:
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; reset is asserted when low.
- io_in_valid  input  1  event present.
- io_in_ready  output  1  block can accept an event this cycle.
- io_in_sel  input  SEL_W  channel index of the event.
- io_out  output  N  registered one-hot of the last accepted io_in_sel.
- io_rd_sel  input  SEL_W  channel to read back.
- io_rd_cnt  output  CNT_W  registered count of channel io_rd_sel.
- io_clear  input  1  single-cycle request to zero all counters.
- io_busy  output  1  clear sweep in progress.
- io_ovf  output  1  sticky flag: some counter wrapped or saturated.

## Operation
- The FSM has two states, IDLE and CLEAR.
- io_in_ready = (state==IDLE) && !io_clear.
- An event is accepted when io_in_valid && io_in_ready.
- On acceptance:
  - io_out <= one-hot(io_in_sel).
  - cnt[io_in_sel] <= cnt[io_in_sel] + 1. Arithmetic is modulo 2^CNT_W unless saturation is enabled (see Configuration).
- Increment at cnt == 2^CNT_W-1 sets io_ovf.
- Cycles with no acceptance leave io_out unchanged; it holds the last decode.
- IDLE -> CLEAR when io_clear=1 in IDLE.
  - io_clear wins over a simultaneous io_in_valid; that event is not accepted because ready is low.
  - The sweep index resets to 0.
- In CLEAR, one counter is zeroed per cycle at index idx, then idx increments.
  - After zeroing index N-1, the FSM returns to IDLE, and io_ovf and io_out clear in that same cycle.
  - io_clear asserted during CLEAR is ignored; the sweep does not restart.
- io_busy = (state==CLEAR).
- io_rd_cnt <= cnt[io_rd_sel] every cycle, including during CLEAR. The read sees the pre-edge register value, so a same-cycle increment shows one cycle later.
- Reset values: io_out=0, io_rd_cnt=0, io_ovf=0, io_busy=0, all cnt=0, state=IDLE, idx=0. io_in_ready is 1 out of reset (io_clear low).
- Reset assertion mid-sweep or mid-count immediately forces all of the above. No partial state survives.

## Timing
- Event to io_out: 1 cycle (visible after the accepting edge).
- Event to io_rd_cnt reflecting it: 2 cycles when io_rd_sel is held on that channel.
- Clear: io_in_ready drops combinationally in the io_clear cycle and stays low for exactly N cycles after it. The first accept is possible N+1 cycles after the io_clear cycle.
- Back-to-back events are accepted at full rate (one per cycle) in IDLE, including repeated hits on the same channel.
- All outputs except io_in_ready are registered.
- Reset deassertion is synchronised externally; the block needs no internal synchroniser.

## Configuration
- ONEHOT_CNT_SATURATE_EN:
  - Defined: counters saturate at 2^CNT_W-1. An increment at max leaves the value at max and sets io_ovf.
  - Undefined: counters wrap to 0 on that increment and set io_ovf.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold reset low 3 cycles with io_in_valid=1, sel=5 -> io_out=0, all counts 0, io_ovf=0, io_busy=0. After release, io_in_ready=1.
- Decode/count: defaults, accept sel=0,3,3,7 on consecutive cycles -> io_out=0x01, 0x08, 0x08, 0x80. Readback gives ch3=2, ch7=1, ch1=0.
- Overflow: CNT_W=2, 4 events on ch2. Without macro -> count 0, io_ovf=1. With ONEHOT_CNT_SATURATE_EN -> count 3, io_ovf=1.
- Clear collision: io_clear and io_in_valid with sel=1 in the same cycle -> event not accepted, io_busy=1 for 8 cycles. Counts all 0, io_out=0 and io_ovf=0 after the sweep. A second io_clear mid-sweep does not extend it.
- Reset mid-sweep: assert reset at sweep cycle 3 -> state IDLE, idx 0, all counts 0 immediately (asynchronously).
- Parametrisation: SEL_W=1, CNT_W=4, 16 events on ch1 -> io_out=0b10, count 0 (wrap), io_ovf=1, ch0 count 0.
